// File: rtl/sevenseg2letra_reader_if.sv
// Segment bus and event-FIFO handshake between a seven-segment display source and the reader.
interface sevenseg2letra_reader_if #(parameter int NUM_DIGITS = 4) ();
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [7:0]            display;
  logic [NUM_DIGITS-1:0] dig_en;
  logic                  out_valid;
  logic                  out_ready;
  logic [4:0]            out_letra;
  logic [DW-1:0]         out_digit;
  logic                  out_err;
  logic                  overflow;

  modport master (output display, dig_en, out_ready,
                  input  out_valid, out_letra, out_digit, out_err, overflow);
  modport slave  (input  display, dig_en, out_ready,
                  output out_valid, out_letra, out_digit, out_err, overflow);
endinterface

// File: rtl/sevenseg2letra_reader.sv
// Recovers letter codes from a multiplexed seven-segment bus and queues per-digit stable changes.
// Optional macro LETRA_ERR_REPORT_EN: report stable unmatched patterns as err events (letra 5'h1F).
module sevenseg2letra_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int STABLE_SCANS  = 3,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sevenseg2letra_reader_if.slave   bus
);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 1 + 5 + DW;
`ifdef LETRA_ERR_REPORT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  function automatic logic [5:0] decode(input logic [7:0] p);
    case (p)
      8'b00000000: decode = {1'b1, 5'h00};
      8'b11111001: decode = {1'b1, 5'h01};
      8'b01011011: decode = {1'b1, 5'h02};
      8'b11000011: decode = {1'b1, 5'h03};
      8'b00111011: decode = {1'b1, 5'h04};
      8'b11010011: decode = {1'b1, 5'h05};
      8'b11010001: decode = {1'b1, 5'h06};
      8'b11111010: decode = {1'b1, 5'h07};
      8'b01111001: decode = {1'b1, 5'h08};
      8'b00101000: decode = {1'b1, 5'h09};
      8'b00101011: decode = {1'b1, 5'h0A};
      8'b01010001: decode = {1'b1, 5'h0B};
      8'b01000011: decode = {1'b1, 5'h0C};
      8'b10001001: decode = {1'b1, 5'h0D};
      8'b11101001: decode = {1'b1, 5'h0E};
      8'b11101011: decode = {1'b1, 5'h0F};
      8'b11110001: decode = {1'b1, 5'h10};
      8'b11111000: decode = {1'b1, 5'h11};
      8'b11000001: decode = {1'b1, 5'h12};
      8'b11011010: decode = {1'b1, 5'h13};
      8'b01010011: decode = {1'b1, 5'h14};
      8'b01101011: decode = {1'b1, 5'h15};
      8'b00001011: decode = {1'b1, 5'h16};
      8'b01100010: decode = {1'b1, 5'h17};
      8'b00111000: decode = {1'b1, 5'h18};
      8'b01111010: decode = {1'b1, 5'h19};
      8'b10110011: decode = {1'b1, 5'h1A};
      default:     decode = {1'b0, 5'h1F};
    endcase
  endfunction

  // settle tracking: run_q counts consecutive edges with the same one-hot dig_en
  logic                  onehot, cap;
  logic [NUM_DIGITS-1:0] dig_prev;
  logic [4:0]            run_q, run_d;
  logic [DW-1:0]         enc;

  assign onehot = $onehot(bus.dig_en);

  always_comb begin
    run_d = 5'd1;
    if (!onehot)
      run_d = '0;
    else if (bus.dig_en == dig_prev)
      run_d = (run_q == 5'(SETTLE_CYCLES + 2)) ? run_q : run_q + 5'd1;
  end

  assign cap = (run_d == 5'(SETTLE_CYCLES + 1));

  always_comb begin
    enc = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (bus.dig_en[i]) enc = DW'(i);
  end

  // capture stage and per-digit stability state
  logic                        cap_v;
  logic [7:0]                  cap_pat;
  logic [DW-1:0]               cap_idx;
  logic [NUM_DIGITS-1:0][7:0]  cand, rep;
  logic [NUM_DIGITS-1:0][2:0]  cnt;
  logic [NUM_DIGITS-1:0]       rep_none;
  logic                        same, reach, fire;
  logic [2:0]                  cnt_old, cnt_new;
  logic [5:0]                  dec;

  assign same    = (cap_pat == cand[cap_idx]);
  assign cnt_old = cnt[cap_idx];
  assign cnt_new = !same ? 3'd1 : (cnt_old == 3'(STABLE_SCANS)) ? cnt_old : cnt_old + 3'd1;
  // a saturated, unchanged candidate does not re-reach the threshold
  assign reach   = (cnt_new == 3'(STABLE_SCANS)) && !(same && cnt_old == 3'(STABLE_SCANS));
  assign dec     = decode(cap_pat);
  assign fire    = cap_v && reach && (rep_none[cap_idx] || rep[cap_idx] != cap_pat)
                   && (dec[5] || ERR_EN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dig_prev <= '0;
      run_q    <= '0;
      cap_v    <= 1'b0;
      cap_pat  <= '0;
      cap_idx  <= '0;
      cand     <= '0;
      cnt      <= '0;
      rep      <= '0;
      rep_none <= '1;
    end else begin
      dig_prev <= bus.dig_en;
      run_q    <= run_d;
      cap_v    <= cap;
      if (cap) begin
        cap_pat <= bus.display;
        cap_idx <= enc;
      end
      if (cap_v) begin
        cand[cap_idx] <= cap_pat;
        cnt[cap_idx]  <= cnt_new;
      end
      if (fire) begin
        rep[cap_idx]      <= cap_pat;
        rep_none[cap_idx] <= 1'b0;
      end
    end
  end

  // event FIFO; a full FIFO still accepts when the head pops on the same edge
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count;
  logic          full, pop, push, ovf;
  logic [EW-1:0] ev, head;

  assign full = (count == (AW+1)'(FIFO_DEPTH));
  assign pop  = bus.out_valid && bus.out_ready;
  assign push = fire && (!full || pop);
  assign ev   = {ERR_EN & ~dec[5], dec[4:0], cap_idx};
  assign head = mem[rp];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (fire && full && !pop) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= ev;
  end

  assign bus.out_valid = (count != '0);
  assign bus.out_err   = bus.out_valid & head[EW-1];
  assign bus.out_letra = bus.out_valid ? head[DW +: 5] : 5'd0;
  assign bus.out_digit = bus.out_valid ? head[DW-1:0] : '0;
  assign bus.overflow  = ovf;
endmodule

// File: doc/sevenseg2letra_reader.md
Name: sevenseg2letra_reader

Overview:
- Reverse end of the letter-to-seven-segment path. Watches a multiplexed 8-bit segment bus plus per-digit enables, and recovers the 5-bit letter code shown on each digit.
- Reports each newly stable letter per digit through a small valid/ready FIFO.
- Used for display self-check and loopback (letter encoder output -> this block -> compare against sent letters).

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8)
- SETTLE_CYCLES, 2, cycles dig_en must hold before display is captured (0..15)
- STABLE_SCANS, 3, consecutive identical captures on a digit before it is reported (1..7)
- FIFO_DEPTH, 4, event FIFO entries (power of 2, 2..16)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- display  in  8  segment pattern currently driven
- dig_en  in  NUM_DIGITS  digit enable, active-high, one-hot when valid
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_letra  out  5  recovered letter code
- out_digit  out  clog2(NUM_DIGITS)  digit index of event
- out_err  out  1  pattern not in table (only with LETRA_ERR_REPORT_EN; else tied 0)
- overflow  out  1  sticky: event lost because FIFO full

Behaviour:
- Reset (rst_n=0 at an edge): FIFO empty, out_valid=0, out_letra=0, out_digit=0, out_err=0, overflow=0. All per-digit candidate/count/reported state is cleared; reported is marked "none". Reset mid-operation discards pending events and any partial settle/stability count.
- Capture: the settle counter restarts whenever dig_en differs from its previous-cycle value. dig_en that is not one-hot (zero or multi-hot) never captures and holds the counter at 0. display is captured exactly once per activation, at the (SETTLE_CYCLES+1)th consecutive edge with the same one-hot dig_en. A shorter activation captures nothing.
- Decode table, pattern -> letra, exact 8-bit match:
  00000000->00, 11111001->01, 01011011->02, 11000011->03, 00111011->04, 11010011->05, 11010001->06, 11111010->07, 01111001->08, 00101000->09, 00101011->0A, 01010001->0B, 01000011->0C, 10001001->0D, 11101001->0E, 11101011->0F, 11110001->10, 11111000->11, 11000001->12, 11011010->13, 01010011->14, 01101011->15, 00001011->16, 01100010->17, 00111000->18, 01111010->19, 10110011->1A.
  Any other pattern is unmatched.
- Stability, per digit d, processed the edge after capture:
  - If the capture equals cand[d], cnt[d] increments, saturating at STABLE_SCANS.
  - Otherwise cand[d] takes the capture and cnt[d]=1.
  - An event fires on the edge cnt[d] reaches STABLE_SCANS, provided reported[d] is "none" or differs from cand[d]. reported[d] then takes cand[d].
- Events push {letra, digit, err} into the FIFO on that same edge. out_valid rises after the push edge. Latency is 2 edges from the final capture to visible out_valid.
- Pop on an edge with out_valid&&out_ready. Output order is FIFO order.
- Push while full without a simultaneous pop: the event is dropped, overflow=1 (sticky until reset), and reported[d] still updates. Push and pop on the same edge when full: no drop.
- Outputs hold stable while out_valid=1 and out_ready=0.
- Unmatched pattern without LETRA_ERR_REPORT_EN: stability tracking still runs, but no event is pushed and reported[d] is not updated.

Optional Feature:
LETRA_ERR_REPORT_EN:
- Defined: unmatched stable patterns push an event with out_err=1, out_letra=5'h1F, and update reported[d].
- Undefined: unmatched patterns are dropped silently and out_err is constant 0.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles, then dig_en=0 for 20 cycles -> out_valid=0, overflow=0 throughout.
- Basic decode (SETTLE=2, STABLE=3): scan digit 0 with display=01011011 for 3 activations of 4 cycles each -> one event, letra=02, digit=0, out_valid high 2 edges after the 3rd capture; further identical scans give no event.
- Short activation: dig_en=0001 held for 2 cycles between valid scans -> no capture, count unchanged.
- Change and backpressure: all 4 digits go stable with 00,01,1A,0D while out_ready=0 -> 4 entries, no overflow; a 5th change on digit 0 to 07 -> overflow=1; then out_ready=1 -> 00,01,1A,0D pop in order.
- Unmatched: digit 2 stable at 11111111 -> no event without the macro; with LETRA_ERR_REPORT_EN -> event out_err=1, letra=1F.
- Mid-run reset: assert rst_n=0 while 2 entries are queued and cnt=2 -> queue empty, next event needs 3 fresh captures.
